// File: rtl/rvm_axi4_sram_pkg.sv
// Shared constants for the AXI4 word SRAM: response codes, the only legal burst size and FSM encodings.
// Optional build macro: RVM_AXI_SRAM_ALIGN_CHECK_EN (sub-word address check, see rvm_axi4_sram.sv).
package rvm_axi4_sram_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t  RESP_OKAY   = 2'b00;
    localparam axi_resp_t  RESP_SLVERR = 2'b10;
    localparam axi_resp_t  RESP_DECERR = 2'b11;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_WRESP = 2'd2;
    localparam logic [1:0] ST_RRESP = 2'd3;

    // Decode outcome wins over size, which wins over alignment.
    function automatic axi_resp_t resp_of(input logic in_win, input logic [2:0] size,
                                          input logic misalign);
        if (!in_win)
            return RESP_DECERR;
        if ((size != SIZE_WORD) || misalign)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/rvm_axi4_sram_if.sv
// AXI4 single-beat channel bundle between the core bridge (master) and the word SRAM (slave).
interface rvm_axi4_sram_if;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARREADY;
    logic [2:0]  S_AXI_ARSIZE;
    logic        S_AXI_ARVALID;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWREADY;
    logic [2:0]  S_AXI_AWSIZE;
    logic        S_AXI_AWVALID;
    logic [31:0] S_AXI_WDATA;
    logic        S_AXI_WREADY;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_BREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic [31:0] S_AXI_RDATA;
    logic        S_AXI_RREADY;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;

    modport slave (
        input  S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARVALID,
        input  S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_RREADY,
        output S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARVALID,
        output S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_RREADY,
        input  S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/rvm_sram_array.sv
// Synchronous single-port 32-bit RAM with per-byte write enables and one-cycle registered read.
// No reset: contents and read register survive ARESET.
module rvm_sram_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    // One narrow array per byte lane keeps byte writes a plain RAM write-enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (wen[gi])
                        r_mem[addr] <= wdata[8*gi +: 8];
                    r_q <= r_mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = r_q;
        end
    endgenerate

endmodule

// File: rtl/rvm_axi4_sram.sv
// AXI4 slave word SRAM: one transaction at a time, programmable wait states, DECERR outside the window.
// Optional build macro RVM_AXI_SRAM_ALIGN_CHECK_EN: non-word-aligned addresses return SLVERR.
module rvm_axi4_sram
    import rvm_axi4_sram_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input logic          ACLK,
    input logic          ARESET,
    rvm_axi4_sram_if.slave s_axi
);
    localparam logic [7:0] LP_WAIT = 8'(WAIT_CYCLES);

    logic [1:0]  r_state;
    logic        r_aw_held, r_w_held, r_op_write, r_acc;
    logic [31:0] r_awaddr, r_araddr, r_wdata, r_rdata;
    logic [2:0]  r_awsize, r_arsize;
    logic [3:0]  r_wstrb;
    logic [7:0]  r_cnt;
    axi_resp_t   r_resp;

    logic        w_idle, w_awready, w_wready, w_arready;
    logic        w_aw_hs, w_w_hs, w_ar_hs, w_wr_start;
    logic [31:0] w_addr, w_ram_rdata;
    logic [2:0]  w_size;
    logic        w_in_win, w_misalign, w_access, w_ram_en;
    logic [3:0]  w_ram_wen;
    axi_resp_t   w_resp;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_awready = w_idle && !r_aw_held;
    assign w_wready  = w_idle && !r_w_held;
    // Any write activity blocks reads, so a write beats a simultaneous read.
    assign w_arready = w_idle && !r_aw_held && !r_w_held
                       && !s_axi.S_AXI_AWVALID && !s_axi.S_AXI_WVALID;

    assign w_aw_hs    = s_axi.S_AXI_AWVALID && w_awready;
    assign w_w_hs     = s_axi.S_AXI_WVALID && w_wready;
    assign w_ar_hs    = s_axi.S_AXI_ARVALID && w_arready;
    assign w_wr_start = w_idle && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_addr   = r_op_write ? r_awaddr : r_araddr;
    assign w_size   = r_op_write ? r_awsize : r_arsize;
    assign w_in_win = (w_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
`ifdef RVM_AXI_SRAM_ALIGN_CHECK_EN
    assign w_misalign = (w_addr[1:0] != 2'b00);
`else
    logic w_unused_low;
    assign w_misalign   = 1'b0;
    assign w_unused_low = ^w_addr[1:0];
`endif
    assign w_resp = resp_of(w_in_win, w_size, w_misalign);

    // The array is touched exactly once, in the first WAIT cycle with the counter at zero.
    assign w_access  = (r_state == ST_WAIT) && (r_cnt == 8'd0) && !r_acc && !ARESET;
    assign w_ram_en  = w_access && (w_resp == RESP_OKAY);
    assign w_ram_wen = (w_ram_en && r_op_write) ? r_wstrb : 4'b0000;

    rvm_sram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (ACLK),
        .en    (w_ram_en),
        .wen   (w_ram_wen),
        .addr  (w_addr[ADDR_W+1:2]),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state    <= ST_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_op_write <= 1'b0;
            r_acc      <= 1'b0;
            r_cnt      <= 8'd0;
            r_resp     <= RESP_OKAY;
            r_rdata    <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s_axi.S_AXI_AWADDR;
                        r_awsize  <= s_axi.S_AXI_AWSIZE;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s_axi.S_AXI_WDATA;
                        r_wstrb  <= s_axi.S_AXI_WSTRB;
                    end
                    if (w_ar_hs) begin
                        r_araddr <= s_axi.S_AXI_ARADDR;
                        r_arsize <= s_axi.S_AXI_ARSIZE;
                    end
                    if (w_wr_start || w_ar_hs) begin
                        r_state    <= ST_WAIT;
                        r_op_write <= w_wr_start;
                        r_cnt      <= LP_WAIT;
                        r_acc      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (!r_acc) begin
                        r_acc <= 1'b1;
                    end else begin
                        r_resp <= w_resp;
                        if (!r_op_write)
                            r_rdata <= (w_resp == RESP_OKAY) ? w_ram_rdata : 32'h0;
                        r_state <= r_op_write ? ST_WRESP : ST_RRESP;
                    end
                end
                ST_WRESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        r_state   <= ST_IDLE;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                    end
                end
                default: begin
                    if (s_axi.S_AXI_RREADY)
                        r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = !ARESET && w_awready;
    assign s_axi.S_AXI_WREADY  = !ARESET && w_wready;
    assign s_axi.S_AXI_ARREADY = !ARESET && w_arready;
    assign s_axi.S_AXI_BVALID  = !ARESET && (r_state == ST_WRESP);
    assign s_axi.S_AXI_RVALID  = !ARESET && (r_state == ST_RRESP);
    assign s_axi.S_AXI_BRESP   = s_axi.S_AXI_BVALID ? r_resp : RESP_OKAY;
    assign s_axi.S_AXI_RRESP   = s_axi.S_AXI_RVALID ? r_resp : RESP_OKAY;
    assign s_axi.S_AXI_RDATA   = ARESET ? 32'h0 : r_rdata;

endmodule

// File: tb/tb_rvm_axi4_sram.sv
// Directed bench for rvm_axi4_sram: one master drives either a zero-wait (sel=0) or a three-wait (sel=1) instance.
module tb_rvm_axi4_sram;
    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic        sel;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic [2:0]  m_arsize, m_awsize;
    logic [3:0]  m_wstrb;
    logic        m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready;

    logic        s_arready, s_awready, s_wready, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    rvm_axi4_sram_if if0();
    rvm_axi4_sram_if if3();

    rvm_axi4_sram #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(if0.slave));
    rvm_axi4_sram #(.ADDR_W(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_dut3 (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(if3.slave));

    assign if0.S_AXI_ARADDR  = m_araddr;   assign if3.S_AXI_ARADDR  = m_araddr;
    assign if0.S_AXI_ARSIZE  = m_arsize;   assign if3.S_AXI_ARSIZE  = m_arsize;
    assign if0.S_AXI_AWADDR  = m_awaddr;   assign if3.S_AXI_AWADDR  = m_awaddr;
    assign if0.S_AXI_AWSIZE  = m_awsize;   assign if3.S_AXI_AWSIZE  = m_awsize;
    assign if0.S_AXI_WDATA   = m_wdata;    assign if3.S_AXI_WDATA   = m_wdata;
    assign if0.S_AXI_WSTRB   = m_wstrb;    assign if3.S_AXI_WSTRB   = m_wstrb;
    assign if0.S_AXI_ARVALID = m_arvalid && !sel;  assign if3.S_AXI_ARVALID = m_arvalid && sel;
    assign if0.S_AXI_AWVALID = m_awvalid && !sel;  assign if3.S_AXI_AWVALID = m_awvalid && sel;
    assign if0.S_AXI_WVALID  = m_wvalid && !sel;   assign if3.S_AXI_WVALID  = m_wvalid && sel;
    assign if0.S_AXI_BREADY  = m_bready && !sel;   assign if3.S_AXI_BREADY  = m_bready && sel;
    assign if0.S_AXI_RREADY  = m_rready && !sel;   assign if3.S_AXI_RREADY  = m_rready && sel;

    assign s_arready = sel ? if3.S_AXI_ARREADY : if0.S_AXI_ARREADY;
    assign s_awready = sel ? if3.S_AXI_AWREADY : if0.S_AXI_AWREADY;
    assign s_wready  = sel ? if3.S_AXI_WREADY  : if0.S_AXI_WREADY;
    assign s_bvalid  = sel ? if3.S_AXI_BVALID  : if0.S_AXI_BVALID;
    assign s_bresp   = sel ? if3.S_AXI_BRESP   : if0.S_AXI_BRESP;
    assign s_rvalid  = sel ? if3.S_AXI_RVALID  : if0.S_AXI_RVALID;
    assign s_rresp   = sel ? if3.S_AXI_RRESP   : if0.S_AXI_RRESP;
    assign s_rdata   = sel ? if3.S_AXI_RDATA   : if0.S_AXI_RDATA;

    // lat = rising edges from the capturing edge to the first sample with BVALID high (50 = timed out)
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] sz, output logic [1:0] resp, output int lat);
        logic aw_done, w_done, a_hs, w_hs;
        int n;
        @(posedge ACLK); #1;
        m_awaddr = a; m_awsize = sz; m_awvalid = 1'b1;
        m_wdata = d; m_wstrb = s; m_wvalid = 1'b1; m_bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge ACLK);
            a_hs = m_awvalid && s_awready;
            w_hs = m_wvalid && s_wready;
            @(posedge ACLK); #1;
            if (a_hs) begin m_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs) begin m_wvalid = 1'b0; w_done = 1'b1; end
            n++;
        end
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge ACLK);
            if (s_bvalid) break;
            @(posedge ACLK); #1;
            lat++;
        end
        resp = s_bresp;
        @(posedge ACLK); #1;
        m_bready = 1'b0;
        $display("write dut%0d addr=%h data=%h strb=%b size=%0d -> bresp=%b lat=%0d",
                 sel ? 3 : 0, a, d, s, sz, resp, lat);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] sz,
                           output logic [31:0] d, output logic [1:0] resp, output int lat);
        logic done, hs;
        int n;
        @(posedge ACLK); #1;
        m_araddr = a; m_arsize = sz; m_arvalid = 1'b1; m_rready = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 50) begin
            @(negedge ACLK);
            hs = m_arvalid && s_arready;
            @(posedge ACLK); #1;
            if (hs) begin m_arvalid = 1'b0; done = 1'b1; end
            n++;
        end
        m_arvalid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge ACLK);
            if (s_rvalid) break;
            @(posedge ACLK); #1;
            lat++;
        end
        d = s_rdata; resp = s_rresp;
        @(posedge ACLK); #1;
        m_rready = 1'b0;
        $display("read  dut%0d addr=%h size=%0d -> rdata=%h rresp=%b lat=%0d",
                 sel ? 3 : 0, a, sz, d, resp, lat);
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        n_checks++;
        if ({if0.S_AXI_ARREADY, if0.S_AXI_AWREADY, if0.S_AXI_WREADY, if0.S_AXI_BVALID, if0.S_AXI_RVALID,
             if0.S_AXI_BRESP, if0.S_AXI_RRESP, if0.S_AXI_RDATA,
             if3.S_AXI_ARREADY, if3.S_AXI_AWREADY, if3.S_AXI_WREADY, if3.S_AXI_BVALID, if3.S_AXI_RVALID,
             if3.S_AXI_BRESP, if3.S_AXI_RRESP, if3.S_AXI_RDATA} !== 82'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: dut0 rdata=%h dut3 rdata=%h readies0=%b, all required 0",
                     if0.S_AXI_RDATA, if3.S_AXI_RDATA,
                     {if0.S_AXI_ARREADY, if0.S_AXI_AWREADY, if0.S_AXI_WREADY});
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if ({s_arready, s_awready, s_wready, s_bvalid, s_rvalid} !== 5'b11100) begin
            n_fail++;
            $display("FAIL idle_readies: got %b required 11100",
                     {s_arready, s_awready, s_wready, s_bvalid, s_rvalid});
        end
    endtask

    task automatic test_write_okay();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010, resp, lat);
        n_checks++;
        if ({resp, 6'(lat)} !== {2'b00, 6'd2}) begin
            n_fail++;
            $display("FAIL write_okay_b: bresp=%b lat=%0d required bresp=00 lat=2", resp, lat);
        end
        do_read(32'h10, 3'b010, d, resp, lat);
        n_checks++;
        if ({d, resp, 6'(lat)} !== {32'hDEAD_BEEF, 2'b00, 6'd2}) begin
            n_fail++;
            $display("FAIL write_okay_r: rdata=%h rresp=%b lat=%0d required deadbeef 00 2", d, resp, lat);
        end
    endtask

    task automatic test_byte_strobes();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(32'h20, 32'h1122_3344, 4'hF, 3'b010, resp, lat);
        do_write(32'h20, 32'hAABB_CCDD, 4'b0101, 3'b010, resp, lat);
        do_read(32'h20, 3'b010, d, resp, lat);
        n_checks++;
        if ({d, resp} !== {32'h11BB_33DD, 2'b00}) begin
            n_fail++;
            $display("FAIL byte_strobes: rdata=%h rresp=%b required 11bb33dd 00", d, resp);
        end
    endtask

    task automatic test_split_write();
        logic [1:0] resp; logic [31:0] d; int lat; logic ok, ar_early;
        @(posedge ACLK); #1;
        m_wdata = 32'h5566_7788; m_wstrb = 4'hF; m_wvalid = 1'b1;
        m_araddr = 32'h10; m_arsize = 3'b010; m_arvalid = 1'b1;
        m_rready = 1'b1; m_bready = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if ({s_wready, s_arready} !== 2'b10) begin
            n_fail++;
            $display("FAIL split_w_first: wready,arready=%b required 10", {s_wready, s_arready});
        end
        @(posedge ACLK); #1;
        m_wvalid = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            if (s_wready || s_arready || s_bvalid) ok = 1'b0;
            @(posedge ACLK); #1;
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL split_hold: wready/arready/bvalid seen high while only W held, required all 0");
        end
        m_awaddr = 32'h40; m_awsize = 3'b010; m_awvalid = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        m_awvalid = 1'b0;
        lat = 0; ar_early = 1'b0;
        while (lat < 50) begin
            @(negedge ACLK);
            if (s_arready) ar_early = 1'b1;
            if (s_bvalid) break;
            @(posedge ACLK); #1;
            lat++;
        end
        $display("write dut0 split addr=00000040 -> bresp=%b lat=%0d", s_bresp, lat);
        n_checks++;
        if ({s_bresp, 6'(lat), ar_early} !== {2'b00, 6'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL split_b: bresp=%b lat=%0d ar_early=%b required 00 2 0", s_bresp, lat, ar_early);
        end
        @(posedge ACLK); #1;
        @(negedge ACLK);
        n_checks++;
        if (s_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL split_ar_after: arready=%b required 1", s_arready);
        end
        @(posedge ACLK); #1;
        m_arvalid = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge ACLK);
            if (s_rvalid) break;
            @(posedge ACLK); #1;
            lat++;
        end
        $display("read  dut0 held-off addr=00000010 -> rdata=%h rresp=%b", s_rdata, s_rresp);
        n_checks++;
        if ({s_rdata, s_rresp} !== {32'hDEAD_BEEF, 2'b00}) begin
            n_fail++;
            $display("FAIL split_ar_data: rdata=%h rresp=%b required deadbeef 00", s_rdata, s_rresp);
        end
        @(posedge ACLK); #1;
        m_rready = 1'b0; m_bready = 1'b0;
        do_read(32'h40, 3'b010, d, resp, lat);
        n_checks++;
        if ({d, resp} !== {32'h5566_7788, 2'b00}) begin
            n_fail++;
            $display("FAIL split_data: rdata=%h rresp=%b required 55667788 00", d, resp);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [31:0] d; int lat;
        do_write(32'h0, 32'h0102_0304, 4'hF, 3'b010, resp, lat);
        do_read(32'h0000_1000, 3'b010, d, resp, lat);
        n_checks++;
        if ({d, resp} !== {32'h0, 2'b11}) begin
            n_fail++;
            $display("FAIL decerr_read: rdata=%h rresp=%b required 00000000 11", d, resp);
        end
        do_write(32'h0000_1000, 32'hCAFE_F00D, 4'hF, 3'b010, resp, lat);
        n_checks++;
        if (resp !== 2'b11) begin
            n_fail++;
            $display("FAIL decerr_write: bresp=%b required 11", resp);
        end
        do_read(32'h0, 3'b010, d, resp, lat);
        n_checks++;
        if ({d, resp} !== {32'h0102_0304, 2'b00}) begin
            n_fail++;
            $display("FAIL decerr_nowrite: rdata=%h required 01020304", d);
        end
        do_read(32'h10, 3'b001, d, resp, lat);
        n_checks++;
        if ({d, resp} !== {32'h0, 2'b10}) begin
            n_fail++;
            $display("FAIL slverr_read: rdata=%h rresp=%b required 00000000 10", d, resp);
        end
        do_write(32'h10, 32'h0, 4'hF, 3'b011, resp, lat);
        do_read(32'h10, 3'b010, d, resp, lat);
        n_checks++;
        if (d !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL slverr_nowrite: rdata=%h required deadbeef", d);
        end
        do_write(32'hFFC, 32'hA5A5_5A5A, 4'hF, 3'b010, resp, lat);
        do_read(32'hFFC, 3'b010, d, resp, lat);
        n_checks++;
        if ({d, resp} !== {32'hA5A5_5A5A, 2'b00}) begin
            n_fail++;
            $display("FAIL top_word: rdata=%h rresp=%b required a5a55a5a 00", d, resp);
        end
    endtask

    task automatic test_align();
        logic [1:0] resp; logic [31:0] d; logic [33:0] exp_v; int lat;
`ifdef RVM_AXI_SRAM_ALIGN_CHECK_EN
        exp_v = {32'h0, 2'b10};
`else
        exp_v = {32'hDEAD_BEEF, 2'b00};
`endif
        do_read(32'h12, 3'b010, d, resp, lat);
        n_checks++;
        if ({d, resp} !== exp_v) begin
            n_fail++;
            $display("FAIL align: rdata=%h rresp=%b required %h %b", d, resp, exp_v[33:2], exp_v[1:0]);
        end
    endtask

    task automatic test_back_pressure();
        logic [1:0] resp; logic [31:0] d0; int lat; logic ok, ar_early;
        sel = 1'b1;
        do_write(32'h50, 32'h0BAD_F00D, 4'hF, 3'b010, resp, lat);
        n_checks++;
        if ({resp, 6'(lat)} !== {2'b00, 6'd5}) begin
            n_fail++;
            $display("FAIL wait3_write: bresp=%b lat=%0d required 00 5", resp, lat);
        end
        @(posedge ACLK); #1;
        m_araddr = 32'h50; m_arsize = 3'b010; m_arvalid = 1'b1; m_rready = 1'b0;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        m_arvalid = 1'b0;
        lat = 0; ar_early = 1'b0;
        while (lat < 50) begin
            @(negedge ACLK);
            if (s_arready) ar_early = 1'b1;
            if (s_rvalid) break;
            @(posedge ACLK); #1;
            lat++;
        end
        d0 = s_rdata;
        $display("read  dut3 stalled addr=00000050 -> rdata=%h rresp=%b lat=%0d", d0, s_rresp, lat);
        n_checks++;
        if ({d0, s_rresp, 6'(lat), ar_early} !== {32'h0BAD_F00D, 2'b00, 6'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL wait3_read: rdata=%h lat=%0d ar_early=%b required 0badf00d 5 0", d0, lat, ar_early);
        end
        ok = 1'b1;
        repeat (5) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            if (!s_rvalid || s_rdata !== d0 || s_arready) ok = 1'b0;
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_stable: rvalid=%b rdata=%h arready=%b required 1 %h 0", s_rvalid, s_rdata, s_arready, d0);
        end
        @(posedge ACLK); #1;
        m_rready = 1'b1;
        @(posedge ACLK); #1;
        m_rready = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if ({s_rvalid, s_arready} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_release: rvalid,arready=%b required 01", {s_rvalid, s_arready});
        end
    endtask

    task automatic test_reset_midop();
        logic [1:0] resp; logic [31:0] d; int lat; logic silent;
        sel = 1'b1;
        do_write(32'h30, 32'h1234_5678, 4'hF, 3'b010, resp, lat);
        @(posedge ACLK); #1;
        m_awaddr = 32'h30; m_awsize = 3'b010; m_awvalid = 1'b1;
        m_wdata = 32'hFFFF_FFFF; m_wstrb = 4'hF; m_wvalid = 1'b1; m_bready = 1'b1;
        @(posedge ACLK); #1;
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if ({s_arready, s_awready, s_wready, s_bvalid, s_bresp, s_rvalid, s_rresp, s_rdata} !== 41'h0) begin
            n_fail++;
            $display("FAIL midop_outputs: bvalid=%b rdata=%h readies=%b required all 0",
                     s_bvalid, s_rdata, {s_arready, s_awready, s_wready});
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        silent = 1'b1;
        repeat (10) begin
            @(negedge ACLK);
            if (s_bvalid) silent = 1'b0;
        end
        m_bready = 1'b0;
        n_checks++;
        if (silent !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_no_bvalid: bvalid rose after reset, required 0");
        end
        do_read(32'h30, 3'b010, d, resp, lat);
        n_checks++;
        if (d !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL midop_unchanged: rdata=%h required 12345678", d);
        end
    endtask

    initial begin
        sel = 1'b0; ARESET = 1'b1;
        m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_arsize = 3'b010; m_awsize = 3'b010;
        m_wstrb = '0; m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
        m_bready = 1'b0; m_rready = 1'b0;
        test_reset();
        test_write_okay();
        test_byte_strobes();
        test_split_write();
        test_errors();
        test_align();
        test_back_pressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
